// File: rtl/apb_timer_req_arbiter.sv
// APB master that shares one timer APB slave among NUM_REQ requesters.
// Round-robin grant, one transfer outstanding, per-requester response pulse.
//
// Handshake: a requester holds req_valid[i] (with write/addr/wdata stable)
// until it sees req_ready[i] high in the same cycle; that cycle is the accept.
// It may drop req_valid[i] earlier without effect. rsp_valid[i] is a one-cycle
// pulse with no back-pressure; rsp_rdata/rsp_err are only meaningful with it.
module apb_timer_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RD_CAP_DLY  = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [3:0]                    pstrb,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr,
  output logic [2:0]                    dbg_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_gnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [TW-1:0]         r_tmo_cnt;

  logic [2*NUM_REQ-1:0]  w_dbl;
  logic [NUM_REQ-1:0]    w_rot;
  logic [PW-1:0]         w_off;
  logic [PW:0]           w_sum;
  logic [PW-1:0]         w_gnt_idx;
  logic                  w_gnt_vld;
  logic                  w_tmo_hit;

  // Rotate requests so the pointer position becomes bit 0, then take the lowest set bit.
  assign w_dbl = {req_valid, req_valid} >> r_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  // Priority scan over the rotated vector: lowest offset from the pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_off     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_gnt_vld = 1'b1;
        w_off     = PW'(i);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt_idx = (w_sum >= NREQ_W) ? PW'(w_sum - NREQ_W) : PW'(w_sum);
  assign w_tmo_hit = (TIMEOUT_CYC != 0) && (r_tmo_cnt == TMO_LAST);

  // Accept pulse is combinational so it lands in the same cycle as the grant decision.
  always_comb begin
    req_ready = '0;
    if (presetn && (r_state == S_IDLE) && w_gnt_vld) req_ready[w_gnt_idx] = 1'b1;
  end

  // Transfer FSM: grant/latch, APB setup/access, optional delayed read capture, response.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_gnt_vld) begin
            r_gnt   <= w_gnt_idx;
            r_write <= req_write[w_gnt_idx];
            r_addr  <= req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            r_ptr   <= (w_gnt_idx == LAST_REQ) ? '0 : w_gnt_idx + PW'(1);
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_err     <= pslverr;
            r_tmo_cnt <= '0;
            if (r_write) begin
              r_rdata <= '0;
              r_state <= S_RESP;
            end else if (RD_CAP_DLY == 0) begin
              r_rdata <= prdata;
              r_state <= S_RESP;
            end else begin
              r_state <= S_CAPTURE;
            end
          end else if (w_tmo_hit) begin
            // Slave never answered: abort with an error and no data.
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_tmo_cnt <= '0;
            r_state   <= S_RESP;
          end else if (TIMEOUT_CYC != 0) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        S_CAPTURE: begin
          // Slave registered prdata during ACCESS; it is valid on this edge.
          r_rdata <= prdata;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // APB bus outputs are decoded from the state register; zeroed outside a transfer.
  assign psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable = (r_state == S_ACCESS);
  assign paddr   = psel ? r_addr : '0;
  assign pwrite  = psel & r_write;
  assign pwdata  = psel ? r_wdata : '0;
  assign pstrb   = (psel && r_write) ? 4'hF : 4'h0;
  assign busy    = (r_state == S_SETUP) || (r_state == S_ACCESS) || (r_state == S_CAPTURE);

  // Response pulse goes only to the requester that owns the transfer.
  always_comb begin
    rsp_valid = '0;
    if (r_state == S_RESP) rsp_valid[r_gnt] = 1'b1;
  end

  assign rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
  assign rsp_err   = (r_state == S_RESP) & r_err;
  assign dbg_state = r_state;

endmodule
